// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, limits and FSM state for the partial-product accumulator
package mac_pkg;
  localparam int PP_W = 15;
  localparam int EXP_W = 6;
  localparam int QF_W = 5;
  localparam int ACC_W = 19;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W = 5;
  typedef enum logic {IDLE, ACC} state_t;
endpackage

// File: rtl/pp_sat_add.sv
// pp_sat_add: sign-extend a partial product and add it to (or load it into) the accumulator
// Ports: i_acc running sum, i_pp signed partial product, i_load start a new group,
//        i_clamped group already saturated, o_sum next accumulator, o_clamped next sticky flag.
// Build option: PP_ACCUM_SAT_EN clamps on overflow and holds the clamp; otherwise wraps.
module pp_sat_add
  import mac_pkg::*;
#(
  parameter int PP_W = mac_pkg::PP_W,
  parameter int ACC_W = mac_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [PP_W-1:0]  i_pp,
  input  logic             i_load,
  input  logic             i_clamped,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_clamped
);
  logic [ACC_W-1:0] base;
  assign base = i_load ? '0 : i_acc;
`ifdef PP_ACCUM_SAT_EN
  logic [ACC_W:0] wide;
  logic ovf;
  assign wide = {base[ACC_W-1], base} + {{(ACC_W+1-PP_W){i_pp[PP_W-1]}}, i_pp};
  assign ovf = wide[ACC_W] ^ wide[ACC_W-1];
  // once clamped, the group keeps its rail value whatever later beats bring
  assign o_sum = (i_clamped && !i_load) ? i_acc :
                 ovf ? (wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                 wide[ACC_W-1:0];
  assign o_clamped = (i_clamped && !i_load) || ovf;
`else
  assign o_sum = base + {{(ACC_W-PP_W){i_pp[PP_W-1]}}, i_pp};
  assign o_clamped = i_clamped & 1'b0;
`endif
endmodule

// File: rtl/pp_accum.sv
// pp_accum: accumulate signed aligned partial products per group and publish the group sum
// Ports: i_clk, i_rst (sync, active-high), i_valid/i_last beat qualifiers, i_align_pp product,
//        i_max_exp/i_Q_frac group tags; o_valid one-cycle result pulse, o_sum, o_max_exp,
//        o_Q_frac, o_count (beats, saturating at 31) held until the next result.
// Build option: PP_ACCUM_SAT_EN selects saturating instead of wrapping accumulation.
module pp_accum
  import mac_pkg::*;
#(
  parameter int PP_W = mac_pkg::PP_W,
  parameter int ACC_W = mac_pkg::ACC_W,
  parameter int MAX_TERMS = mac_pkg::MAX_TERMS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [PP_W-1:0]  i_align_pp,
  input  logic             i_last,
  input  logic [EXP_W-1:0] i_max_exp,
  input  logic [QF_W-1:0]  i_Q_frac,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_sum,
  output logic [EXP_W-1:0] o_max_exp,
  output logic [QF_W-1:0]  o_Q_frac,
  output logic [CNT_W-1:0] o_count
);
  if (ACC_W < PP_W + $clog2(MAX_TERMS)) begin : g_width_check
    $error("ACC_W too narrow for MAX_TERMS beats of PP_W");
  end
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [EXP_W-1:0] exp_q, exp_grp;
  logic [QF_W-1:0] qf_q, qf_grp;
  logic clamped, clamped_nxt, load, publish;
  pp_sat_add #(.PP_W(PP_W), .ACC_W(ACC_W)) u_add (
    .i_acc(acc), .i_pp(i_align_pp), .i_load(load), .i_clamped(clamped),
    .o_sum(sum), .o_clamped(clamped_nxt)
  );
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    if (i_valid) state_nxt = (state == IDLE && !i_last) ? ACC : (i_last ? IDLE : state);
  end
  // the first beat of a group comes from IDLE, so its tags bypass the capture registers
  always_comb begin
    load = state == IDLE;
    publish = i_valid && i_last;
    cnt_nxt = load ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
    exp_grp = load ? i_max_exp : exp_q;
    qf_grp = load ? i_Q_frac : qf_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc <= '0;
      cnt <= '0;
      exp_q <= '0;
      qf_q <= '0;
      clamped <= 1'b0;
      o_valid <= 1'b0;
      o_sum <= '0;
      o_max_exp <= '0;
      o_Q_frac <= '0;
      o_count <= '0;
    end else begin
      o_valid <= publish;
      if (i_valid) begin
        acc <= sum;
        cnt <= cnt_nxt;
        clamped <= clamped_nxt;
        exp_q <= exp_grp;
        qf_q <= qf_grp;
      end
      if (publish) begin
        o_sum <= sum;
        o_count <= cnt_nxt;
        o_max_exp <= exp_grp;
        o_Q_frac <= qf_grp;
      end
    end
  end
endmodule

// File: tb/tb_pp_accum.sv
// tb_pp_accum: directed table-driven check of pp_accum plus long-group sequences
module tb_pp_accum;
  logic clk = 1'b0;
  logic rst, valid, last;
  logic [14:0] pp;
  logic [5:0] mexp;
  logic [4:0] qf;
  logic ov;
  logic [18:0] osum;
  logic [5:0] oexp;
  logic [4:0] oqf;
  logic [4:0] ocnt;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  pp_accum dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_align_pp(pp), .i_last(last),
    .i_max_exp(mexp), .i_Q_frac(qf), .o_valid(ov), .o_sum(osum), .o_max_exp(oexp),
    .o_Q_frac(oqf), .o_count(ocnt)
  );
  typedef struct {
    logic rst, valid, last;
    logic [14:0] pp;
    logic [5:0] mexp;
    logic [4:0] qf;
    logic e_valid;
    logic [18:0] e_sum;
    logic [4:0] e_cnt;
    logic [5:0] e_exp;
    logic [4:0] e_qf;
  } vec_t;
  vec_t tbl[19];
  task automatic step(input logic r, input logic v, input logic l, input logic [14:0] p,
                      input logic [5:0] e, input logic [4:0] q);
    @(negedge clk);
    rst = r; valid = v; last = l; pp = p; mexp = e; qf = q;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic ev, input logic [18:0] es,
                       input logic [4:0] ec, input logic [5:0] ee, input logic [4:0] eq);
    n_vec++;
    if ({ov, osum, ocnt, oexp, oqf} !== {ev, es, ec, ee, eq}) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b sum=%h cnt=%0d exp=%0d qf=%0d, want valid=%0b sum=%h cnt=%0d exp=%0d qf=%0d",
               name, ov, osum, ocnt, oexp, oqf, ev, es, ec, ee, eq);
    end
  endtask
  initial begin
    logic [18:0] e_ovf;
    rst = 1'b1; valid = 1'b0; last = 1'b0; pp = '0; mexp = '0; qf = '0;
    //          rst  v    l    pp        exp qf  ov   sum       cnt exp qf
    tbl[0]  = '{1'b1,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00000, 0, 0, 0};
    tbl[1]  = '{1'b1,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00000, 0, 0, 0};
    tbl[2]  = '{1'b0,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00000, 0, 0, 0};
    tbl[3]  = '{1'b0,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00000, 0, 0, 0};
    tbl[4]  = '{1'b0,1'b1,1'b0,15'h3800, 9, 3, 1'b0,19'h00000, 0, 0, 0};
    tbl[5]  = '{1'b0,1'b1,1'b1,15'h4800, 9, 3, 1'b1,19'h00000, 2, 9, 3};
    tbl[6]  = '{1'b0,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00000, 2, 9, 3};
    tbl[7]  = '{1'b0,1'b1,1'b1,15'h0005, 4, 1, 1'b1,19'h00005, 1, 4, 1};
    tbl[8]  = '{1'b0,1'b1,1'b0,15'h0001, 7, 2, 1'b0,19'h00005, 1, 4, 1};
    tbl[9]  = '{1'b0,1'b1,1'b0,15'h0002, 8, 6, 1'b0,19'h00005, 1, 4, 1};
    tbl[10] = '{1'b0,1'b1,1'b1,15'h7FFF,12, 9, 1'b1,19'h00002, 3, 7, 2};
    tbl[11] = '{1'b0,1'b1,1'b0,15'h0100, 3, 5, 1'b0,19'h00002, 3, 7, 2};
    tbl[12] = '{1'b0,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00002, 3, 7, 2};
    tbl[13] = '{1'b1,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00000, 0, 0, 0};
    tbl[14] = '{1'b0,1'b1,1'b1,15'h0200, 2, 4, 1'b1,19'h00200, 1, 2, 4};
    tbl[15] = '{1'b0,1'b0,1'b0,15'h0000, 0, 0, 1'b0,19'h00200, 1, 2, 4};
    tbl[16] = '{1'b1,1'b1,1'b1,15'h0033, 5, 5, 1'b0,19'h00000, 0, 0, 0};
    tbl[17] = '{1'b0,1'b1,1'b0,15'h7FFE, 1, 1, 1'b0,19'h00000, 0, 0, 0};
    tbl[18] = '{1'b0,1'b1,1'b1,15'h0003, 6, 6, 1'b1,19'h00001, 2, 1, 1};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].pp, tbl[i].mexp, tbl[i].qf);
      check($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_sum, tbl[i].e_cnt, tbl[i].e_exp, tbl[i].e_qf);
    end
    // 17 beats of +16383 overflow the 19-bit accumulator
`ifdef PP_ACCUM_SAT_EN
    e_ovf = 19'h3FFFF;
`else
    e_ovf = 19'(-245777);
`endif
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 15'h3FFF, 10, 7);
    check("ovf_mid", 1'b0, 19'h00001, 2, 1, 1);
    step(1'b0, 1'b1, 1'b1, 15'h3FFF, 11, 8);
    check("ovf_end", 1'b1, e_ovf, 17, 10, 7);
    // 16 beats of -16384 land exactly on the negative limit
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 15'h4000, 20, 9);
    step(1'b0, 1'b1, 1'b1, 15'h4000, 21, 0);
    check("full16", 1'b1, 19'(-262144), 16, 20, 9);
    step(1'b0, 1'b0, 1'b0, 15'h0000, 0, 0);
    check("full16_hold", 1'b0, 19'(-262144), 16, 20, 9);
    // beat count saturates at 31
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 15'h0001, 30, 31);
    step(1'b0, 1'b1, 1'b1, 15'h0001, 0, 0);
    check("cnt_sat", 1'b1, 19'd33, 31, 30, 31);
    // reset mid-group discards it: no pulse afterwards
    step(1'b0, 1'b1, 1'b0, 15'h0010, 1, 2);
    step(1'b1, 1'b0, 1'b0, 15'h0000, 0, 0);
    check("rst_mid", 1'b0, 19'h00000, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 15'h0000, 0, 0);
    check("rst_mid_quiet", 1'b0, 19'h00000, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pp_accum.md
PP_ACCUM -- requirements
Module: pp_accum

Interface
REQ-001 Parameter PP_W, default 15, width of signed aligned partial product.
REQ-002 Parameter ACC_W, default 19, width of signed accumulator and sum output.
REQ-003 Parameter MAX_TERMS, default 16, largest group size that is guaranteed not to overflow.
REQ-004 Port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port i_rst, input, 1, reset: synchronous, active-high.
REQ-006 Port i_valid, input, 1, beat qualifier from the align stage.
REQ-007 Port i_align_pp, input, PP_W, two's-complement aligned partial product.
REQ-008 Port i_last, input, 1, marks the final beat of a group; ignored when i_valid=0.
REQ-009 Port i_max_exp, input, 6, group exponent, constant within a group.
REQ-010 Port i_Q_frac, input, 5, fraction format tag, constant within a group.
REQ-011 Port o_valid, output, 1, one-cycle pulse when the group result is ready.
REQ-012 Port o_sum, output, ACC_W, signed group sum.
REQ-013 Port o_max_exp, output, 6, exponent of the reported group.
REQ-014 Port o_Q_frac, output, 5, Q_frac of the reported group.
REQ-015 Port o_count, output, 5, number of beats in the reported group (1..31, saturating at 31).

Function
REQ-016 The FSM SHALL have two states. IDLE means no open group. ACC means a group is open.
REQ-017 IDLE with i_valid=1 and i_last=0: load acc=sext(pp), capture exp/Q_frac, cnt=1, go to ACC.
REQ-018 IDLE with i_valid=1 and i_last=1 (single-beat group): result=sext(pp), o_valid next cycle, stay in IDLE.
REQ-019 ACC with i_valid=1: acc+=sext(pp), cnt+=1; if i_last=1, publish the result and return to IDLE.
REQ-020 i_valid=0 in any state: hold all state; a bubble mid-group is legal.
REQ-021 Latency: o_valid asserts exactly 1 cycle after the i_last beat is sampled; back-to-back groups are allowed.
REQ-022 A new group's first beat in the cycle after i_last SHALL load, not add, with no lost beat.
REQ-023 o_valid SHALL be high for exactly one cycle; o_sum/o_max_exp/o_Q_frac/o_count hold until the next publish.
REQ-024 Exponent and Q_frac SHALL be taken from the first beat; later-beat values are ignored.
REQ-025 There is no backpressure: results are never stalled.

Reset
REQ-026 When i_rst=1 at a clock edge: state=IDLE, acc=0, cnt=0, o_valid=0, o_sum=0, o_max_exp=0, o_Q_frac=0, o_count=0.
REQ-027 A reset during ACC SHALL discard the open group; no o_valid is produced for it.
REQ-028 i_rst SHALL dominate i_valid in the same cycle.

Configuration
REQ-029 With macro PP_ACCUM_SAT_EN defined, accumulator overflow SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and stay clamped for the rest of the group.
REQ-030 Without PP_ACCUM_SAT_EN, the accumulator SHALL wrap modulo 2^ACC_W.
REQ-031 With no more than MAX_TERMS beats per group, both builds SHALL give identical results.

Structure
REQ-032 Shared package mac_pkg SHALL hold PP_W, EXP_W=6, QF_W=5, ACC_W, MAX_TERMS and the FSM state enum.
REQ-033 One sub-module, pp_sat_add, SHALL do the sign-extend and add, with optional saturation under the macro; the FSM and registers stay in pp_accum.

Verification
REQ-034 Reset test: i_rst=1 for 2 cycles, then release with no input -> all outputs 0 and o_valid never asserts.
REQ-035 Cancellation test: a 2-beat group pp=0x3800 then pp=0x4800 (last), max_exp=9, Q_frac=3 -> one cycle later o_valid=1, o_sum=0, o_count=2, o_max_exp=9, o_Q_frac=3.
REQ-036 Back-to-back test: single-beat group pp=0x0005 (last), then next cycle a 3-beat group 0x0001, 0x0002, 0x7FFF -> o_sum=5 with count 1; then o_sum=2 with count 3.
REQ-037 Bubble and reset test: group 0x0100, bubble, reset pulse, then 0x0200 (last, new group) -> a single o_valid with o_sum=0x200 and o_count=1.
REQ-038 Overflow test: 17 beats of 0x3FFF -> with PP_ACCUM_SAT_EN, o_sum=0x3FFFF; without it, o_sum=278511 mod 2^19 read as signed = -245777.
REQ-039 Full-size test: 16 beats of 0x4000 (-16384) -> o_sum=-262144 in both builds, o_count=16.
